// File: rtl/cu_vertex_read_request_scheduler_if.sv
// cu_vertex_read_request_scheduler_if: request, command and response channels of the vertex read scheduler
interface cu_vertex_read_request_scheduler_if #(
    parameter int NUM_REQ   = 4,
    parameter int TAG_W     = 4,
    parameter int PAYLOAD_W = 64
);
    logic [NUM_REQ-1:0]           req_valid_in;
    logic [NUM_REQ*PAYLOAD_W-1:0] req_payload_in;
    logic [NUM_REQ-1:0]           req_ready_out;
    logic                         cmd_valid_out;
    logic [PAYLOAD_W-1:0]         cmd_payload_out;
    logic [TAG_W-1:0]             cmd_tag_out;
    logic                         cmd_ready_in;
    logic                         rsp_valid_in;
    logic [TAG_W-1:0]             rsp_tag_in;
    logic [NUM_REQ-1:0]           rsp_valid_out;
    logic [TAG_W-1:0]             rsp_tag_out;
    modport slave (
        input  req_valid_in, req_payload_in, cmd_ready_in, rsp_valid_in, rsp_tag_in,
        output req_ready_out, cmd_valid_out, cmd_payload_out, cmd_tag_out, rsp_valid_out, rsp_tag_out
    );
    modport master (
        output req_valid_in, req_payload_in, cmd_ready_in, rsp_valid_in, rsp_tag_in,
        input  req_ready_out, cmd_valid_out, cmd_payload_out, cmd_tag_out, rsp_valid_out, rsp_tag_out
    );
endinterface

// File: rtl/cu_vertex_read_request_scheduler.sv
// cu_vertex_read_request_scheduler: round-robin read-command arbiter with tag allocation, response routing and drain sequencing
module cu_vertex_read_request_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int TAG_W     = 4,
    parameter int PAYLOAD_W = 64
) (
    input  logic                                    clock,
    input  logic                                    rstn_in,
    input  logic                                    enabled_in,
    cu_vertex_read_request_scheduler_if.slave       bus,
    output logic [TAG_W:0]                          outstanding_out,
    output logic                                    idle_out,
    output logic                                    tag_error_out
);
    localparam int NT = 1 << TAG_W;
    localparam int RW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
    state_t               r_state, w_next;
    logic [NT-1:0]        r_busy, w_busy_next;
    logic [RW-1:0]        r_owner [NT];
    logic [RW-1:0]        r_rr, w_win, w_rr_next;
    logic [TAG_W-1:0]     w_free_tag;
    logic                 w_grant, w_rsp_hit;
    logic                 r_cmd_valid;
    logic [PAYLOAD_W-1:0] r_cmd_payload;
    logic [TAG_W-1:0]     r_cmd_tag;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [TAG_W-1:0]     r_rsp_tag;
    logic [TAG_W:0]       r_outstanding;
    logic                 r_tag_error;
    assign bus.cmd_valid_out   = r_cmd_valid;
    assign bus.cmd_payload_out = r_cmd_payload;
    assign bus.cmd_tag_out     = r_cmd_tag;
    assign bus.rsp_valid_out   = r_rsp_valid;
    assign bus.rsp_tag_out     = r_rsp_tag;
    assign outstanding_out     = r_outstanding;
    assign tag_error_out       = r_tag_error;
    assign idle_out            = (r_state == S_IDLE);
    // Winner scan from the RR pointer (descending so the nearest requester wins) and lowest free tag
    always_comb begin
        w_win      = r_rr;
        w_free_tag = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (bus.req_valid_in[(int'(r_rr) + k) % NUM_REQ]) w_win = RW'((int'(r_rr) + k) % NUM_REQ);
        for (int t = NT - 1; t >= 0; t--)
            if (!r_busy[t]) w_free_tag = TAG_W'(t);
    end
    // Grant only into a free slot with a free tag; tags freed this cycle are not yet visible in r_busy
    always_comb begin
        w_grant           = (r_state == S_RUN) && (!r_cmd_valid || bus.cmd_ready_in) && !(&r_busy) && (|bus.req_valid_in);
        bus.req_ready_out = w_grant ? (NUM_REQ'(1) << w_win) : '0;
        w_rr_next         = (w_win == RW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
        w_rsp_hit         = bus.rsp_valid_in && r_busy[bus.rsp_tag_in];
        w_busy_next       = (r_busy & ~(w_rsp_hit ? (NT'(1) << bus.rsp_tag_in) : '0))
                          | (w_grant ? (NT'(1) << w_free_tag) : '0);
    end
    // Sequencer: a drain always completes to IDLE before the block may run again
    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE && enabled_in) w_next = S_RUN;
        if (r_state == S_RUN && !enabled_in) w_next = S_DRAIN;
        if (r_state == S_DRAIN && !r_cmd_valid && r_outstanding == '0) w_next = S_IDLE;
    end
    // State register
    always_ff @(posedge clock or negedge rstn_in) begin
        if (!rstn_in) r_state <= S_IDLE;
        else          r_state <= w_next;
    end
    // Tag ownership needs no reset: an entry is only read while its busy bit is set
    always_ff @(posedge clock) begin
        if (w_grant) r_owner[w_free_tag] <= w_win;
    end
    // Command slot, busy bitmap, response routing and sticky tag error
    always_ff @(posedge clock or negedge rstn_in) begin
        if (!rstn_in) begin
            r_busy        <= '0;
            r_rr          <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd_payload <= '0;
            r_cmd_tag     <= '0;
            r_rsp_valid   <= '0;
            r_rsp_tag     <= '0;
            r_outstanding <= '0;
            r_tag_error   <= 1'b0;
        end else begin
            r_busy        <= w_busy_next;
            r_outstanding <= (TAG_W+1)'($countones(w_busy_next));
            r_rsp_valid   <= w_rsp_hit ? (NUM_REQ'(1) << r_owner[bus.rsp_tag_in]) : '0;
            r_rsp_tag     <= w_rsp_hit ? bus.rsp_tag_in : '0;
            if (bus.rsp_valid_in && !r_busy[bus.rsp_tag_in]) r_tag_error <= 1'b1;
            if (w_grant) begin
                r_cmd_valid   <= 1'b1;
                r_cmd_payload <= bus.req_payload_in[w_win * PAYLOAD_W +: PAYLOAD_W];
                r_cmd_tag     <= w_free_tag;
                r_rr          <= w_rr_next;
            end else if (bus.cmd_ready_in) begin
                r_cmd_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cu_vertex_read_request_scheduler.sv
// tb_cu_vertex_read_request_scheduler: directed table and corner-case sequences for the read scheduler
module tb_cu_vertex_read_request_scheduler;
    localparam int N = 4;
    localparam int T = 4;
    localparam int P = 64;
    logic         clock = 1'b0;
    logic         rstn_in = 1'b0;
    logic         enabled_in = 1'b0;
    logic [T:0]   outstanding_out;
    logic         idle_out;
    logic         tag_error_out;
    int           total = 0;
    int           bad = 0;
    cu_vertex_read_request_scheduler_if #(.NUM_REQ(N), .TAG_W(T), .PAYLOAD_W(P)) bus ();
    cu_vertex_read_request_scheduler #(.NUM_REQ(N), .TAG_W(T), .PAYLOAD_W(P)) dut (
        .clock(clock), .rstn_in(rstn_in), .enabled_in(enabled_in), .bus(bus),
        .outstanding_out(outstanding_out), .idle_out(idle_out), .tag_error_out(tag_error_out)
    );
    always #5 clock = ~clock;
    typedef struct {
        logic en; logic [3:0] rv; logic cr; logic rspv; logic [3:0] rtag;
        logic [3:0] e_rdy; logic e_cv; logic [3:0] e_tag; logic [63:0] e_pay;
        logic [4:0] e_out; logic [3:0] e_rspv; logic [3:0] e_rtag; logic e_idle;
    } vec_t;
    vec_t tv [21];
    function automatic vec_t mk(input logic en, input logic [3:0] rv, input logic cr, input logic rspv,
                                input logic [3:0] rtag, input logic [3:0] e_rdy, input logic e_cv,
                                input logic [3:0] e_tag, input logic [63:0] e_pay, input logic [4:0] e_out,
                                input logic [3:0] e_rspv, input logic [3:0] e_rtag, input logic e_idle);
        vec_t v;
        v.en = en; v.rv = rv; v.cr = cr; v.rspv = rspv; v.rtag = rtag;
        v.e_rdy = e_rdy; v.e_cv = e_cv; v.e_tag = e_tag; v.e_pay = e_pay;
        v.e_out = e_out; v.e_rspv = e_rspv; v.e_rtag = e_rtag; v.e_idle = e_idle;
        return v;
    endfunction
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic drive(input logic en, input logic [3:0] rv, input logic cr, input logic rspv, input logic [3:0] rtag);
        enabled_in       = en;
        bus.req_valid_in = rv;
        bus.cmd_ready_in = cr;
        bus.rsp_valid_in = rspv;
        bus.rsp_tag_in   = rtag;
        #1;
    endtask
    task automatic do_reset();
        rstn_in = 1'b0;
        drive(1'b0, 4'b0, 1'b1, 1'b0, 4'd0);
        tick();
        chk("rst_idle", 64'(idle_out), 64'd1);
        chk("rst_cmd_valid", 64'(bus.cmd_valid_out), 64'd0);
        chk("rst_outstanding", 64'(outstanding_out), 64'd0);
        chk("rst_tag_error", 64'(tag_error_out), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid_out), 64'd0);
        chk("rst_ready", 64'(bus.req_ready_out), 64'd0);
        rstn_in = 1'b1;
    endtask
    initial begin
        for (int i = 0; i < N; i++) bus.req_payload_in[i*P +: P] = 64'hA3 + 64'(i);
        tv[0] = mk(1, 4'hF, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 16; k++)
            tv[k] = mk(1, 4'hF, 1, 0, 0, 4'(1 << ((k - 1) % 4)), 1, 4'(k - 1),
                       64'hA3 + 64'((k - 1) % 4), 5'(k), 0, 0, 0);
        tv[17] = mk(1, 4'hF, 1, 0, 0, 4'b0000, 0, 0, 0, 5'd16, 0, 0, 0);
        tv[18] = mk(1, 4'hF, 1, 1, 4'd5, 4'b0000, 0, 0, 0, 5'd15, 4'b0010, 4'd5, 0);
        tv[19] = mk(1, 4'hF, 1, 0, 0, 4'b0001, 1, 4'd5, 64'hA3, 5'd16, 0, 0, 0);
        tv[20] = mk(1, 4'hF, 0, 0, 0, 4'b0000, 1, 4'd5, 64'hA3, 5'd16, 0, 0, 0);
        do_reset();
        for (int k = 0; k < 21; k++) begin
            drive(tv[k].en, tv[k].rv, tv[k].cr, tv[k].rspv, tv[k].rtag);
            chk($sformatf("tv%0d_ready", k), 64'(bus.req_ready_out), 64'(tv[k].e_rdy));
            tick();
            chk($sformatf("tv%0d_cmd_valid", k), 64'(bus.cmd_valid_out), 64'(tv[k].e_cv));
            chk($sformatf("tv%0d_outstanding", k), 64'(outstanding_out), 64'(tv[k].e_out));
            chk($sformatf("tv%0d_rsp_valid", k), 64'(bus.rsp_valid_out), 64'(tv[k].e_rspv));
            chk($sformatf("tv%0d_idle", k), 64'(idle_out), 64'(tv[k].e_idle));
            if (tv[k].e_cv) begin
                chk($sformatf("tv%0d_tag", k), 64'(bus.cmd_tag_out), 64'(tv[k].e_tag));
                chk($sformatf("tv%0d_payload", k), bus.cmd_payload_out, tv[k].e_pay);
            end
            if (tv[k].e_rspv != 4'b0) chk($sformatf("tv%0d_rsp_tag", k), 64'(bus.rsp_tag_out), 64'(tv[k].e_rtag));
        end
        do_reset();
        drive(1, 4'b0100, 1, 0, 0);
        chk("single_ready_idle", 64'(bus.req_ready_out), 64'd0);
        tick();
        chk("single_run", 64'(idle_out), 64'd0);
        drive(1, 4'b0100, 1, 0, 0);
        chk("single_ready", 64'(bus.req_ready_out), 64'b0100);
        tick();
        chk("single_cmd_valid", 64'(bus.cmd_valid_out), 64'd1);
        chk("single_payload", bus.cmd_payload_out, 64'hA5);
        chk("single_tag", 64'(bus.cmd_tag_out), 64'd0);
        chk("single_outstanding", 64'(outstanding_out), 64'd1);
        drive(1, 4'b1111, 1, 0, 0);
        chk("rr_after_2", 64'(bus.req_ready_out), 64'b1000);
        tick();
        chk("rr_tag1", 64'(bus.cmd_tag_out), 64'd1);
        chk("rr_payload", bus.cmd_payload_out, 64'hA6);
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'b1111, 0, 0, 0);
            chk($sformatf("stall%0d_ready", i), 64'(bus.req_ready_out), 64'd0);
            tick();
            chk($sformatf("stall%0d_valid", i), 64'(bus.cmd_valid_out), 64'd1);
            chk($sformatf("stall%0d_tag", i), 64'(bus.cmd_tag_out), 64'd1);
            chk($sformatf("stall%0d_payload", i), bus.cmd_payload_out, 64'hA6);
        end
        drive(1, 4'b1111, 1, 0, 0);
        chk("release_ready", 64'(bus.req_ready_out), 64'b0001);
        tick();
        chk("release_tag", 64'(bus.cmd_tag_out), 64'd2);
        chk("release_payload", bus.cmd_payload_out, 64'hA3);
        chk("release_outstanding", 64'(outstanding_out), 64'd3);
        drive(1, 4'b0010, 1, 0, 0);
        chk("own1_ready", 64'(bus.req_ready_out), 64'b0010);
        tick();
        chk("own1_tag", 64'(bus.cmd_tag_out), 64'd3);
        drive(1, 4'b0100, 1, 1, 4'd3);
        chk("simul_ready", 64'(bus.req_ready_out), 64'b0100);
        tick();
        chk("simul_rsp_valid", 64'(bus.rsp_valid_out), 64'b0010);
        chk("simul_rsp_tag", 64'(bus.rsp_tag_out), 64'd3);
        chk("simul_new_tag", 64'(bus.cmd_tag_out), 64'd4);
        chk("simul_outstanding", 64'(outstanding_out), 64'd4);
        drive(1, 4'b1000, 1, 0, 0);
        tick();
        chk("reuse_tag3", 64'(bus.cmd_tag_out), 64'd3);
        chk("reuse_outstanding", 64'(outstanding_out), 64'd5);
        chk("reuse_rsp_pulse", 64'(bus.rsp_valid_out), 64'd0);
        do_reset();
        drive(1, 4'b0000, 1, 0, 0);
        tick();
        drive(1, 4'b0001, 1, 0, 0);
        tick();
        drive(1, 4'b0010, 1, 0, 0);
        tick();
        chk("drain_pre_outstanding", 64'(outstanding_out), 64'd2);
        drive(0, 4'b0000, 1, 0, 0);
        tick();
        chk("drain_idle0", 64'(idle_out), 64'd0);
        chk("drain_cmd_valid", 64'(bus.cmd_valid_out), 64'd0);
        drive(1, 4'b1111, 1, 0, 0);
        chk("drain_no_grant_reenable", 64'(bus.req_ready_out), 64'd0);
        tick();
        drive(0, 4'b1111, 1, 1, 4'd0);
        chk("drain_no_grant", 64'(bus.req_ready_out), 64'd0);
        tick();
        chk("drain_rsp0", 64'(bus.rsp_valid_out), 64'b0001);
        chk("drain_out1", 64'(outstanding_out), 64'd1);
        drive(0, 4'b0000, 1, 1, 4'd1);
        tick();
        chk("drain_rsp1", 64'(bus.rsp_valid_out), 64'b0010);
        chk("drain_out0", 64'(outstanding_out), 64'd0);
        chk("drain_still", 64'(idle_out), 64'd0);
        chk("drain_no_err", 64'(tag_error_out), 64'd0);
        drive(0, 4'b0000, 1, 0, 0);
        tick();
        chk("drain_done_idle", 64'(idle_out), 64'd1);
        drive(0, 4'b0000, 1, 1, 4'd7);
        tick();
        chk("err_set", 64'(tag_error_out), 64'd1);
        chk("err_no_route", 64'(bus.rsp_valid_out), 64'd0);
        drive(0, 4'b0000, 1, 0, 0);
        tick();
        tick();
        chk("err_sticky", 64'(tag_error_out), 64'd1);
        do_reset();
        drive(0, 4'b0000, 1, 1, 4'd0);
        tick();
        chk("err_after_reset", 64'(tag_error_out), 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cu_vertex_read_request_scheduler.md
Name: cu_vertex_read_request_scheduler

Overview:
- Shares the single read-command channel that feeds the vertex cache reuse control among NUM_REQ vertex-side requesters.
- Arbitrates round-robin and allocates a response tag per issued command.
- Bounds in-flight reads to 2^TAG_W and routes each returned response back to the requester that issued it.
- Provides an enable/drain sequencer so a CU can be quiesced cleanly before reconfiguration.

Parameters:
- NUM_REQ, 4: number of requesters; must be ≥2.
- TAG_W, 4: tag width; max outstanding reads = 2^TAG_W = 16.
- PAYLOAD_W, 64: read-command payload width (address, size, array_struct), opaque to this block.

Ports:
- clock  in  1  clock
- rstn_in  in  1  async active-low reset
- enabled_in  in  1  1 = run, 0 = drain and stop issuing
- req_valid_in  in  NUM_REQ  per-requester command valid
- req_payload_in  in  NUM_REQ*PAYLOAD_W  per-requester payload; slice i belongs to requester i
- req_ready_out  out  NUM_REQ  one-hot grant; transfer when valid & ready
- cmd_valid_out  out  1  issued command valid (registered)
- cmd_payload_out  out  PAYLOAD_W  issued payload
- cmd_tag_out  out  TAG_W  allocated tag
- cmd_ready_in  in  1  downstream accepts; low when the read buffer is full
- rsp_valid_in  in  1  response returned
- rsp_tag_in  in  TAG_W  tag of the returned response
- rsp_valid_out  out  NUM_REQ  one-hot response routed to its owner
- rsp_tag_out  out  TAG_W  tag accompanying rsp_valid_out
- outstanding_out  out  TAG_W+1  in-flight count, range 0..2^TAG_W
- idle_out  out  1  1 in IDLE state
- tag_error_out  out  1  sticky; set when a response arrives for a non-busy tag

Behaviour:
- Reset values:
  - all outputs 0, except idle_out = 1;
  - busy bitmap 0, RR pointer 0, state IDLE.
  - Reset mid-operation discards all in-flight state; any later response is flagged as tag_error.
- State machine:
  - IDLE → RUN when enabled_in = 1.
  - RUN → DRAIN when enabled_in = 0.
  - DRAIN → IDLE when cmd_valid_out = 0 and outstanding = 0.
  - enabled_in reasserted during DRAIN does not abort the drain; the block reaches IDLE first, then re-enters RUN.
- Output slot:
  - cmd_valid_out, cmd_payload_out and cmd_tag_out are held stable while cmd_valid_out = 1 and cmd_ready_in = 0.
  - The slot is free when cmd_valid_out = 0 or cmd_ready_in = 1.
- Grant condition (combinational req_ready_out):
  - state = RUN, the slot is free, at least one tag is free, and some req_valid_in is set.
  - Winner = first set bit scanning from the RR pointer upward, modulo NUM_REQ.
  - At most one grant per cycle.
- On grant to requester i:
  - next cycle cmd_valid_out = 1, payload = slice i, tag = lowest-index free tag;
  - busy[tag] set, owner[tag] = i;
  - RR pointer = (i+1) mod NUM_REQ.
- Latency: request accepted in cycle N → command visible in cycle N+1.
- Response handling:
  - rsp_valid_in with busy[rsp_tag_in] = 1: busy cleared; next cycle rsp_valid_out[owner] = 1 (single-cycle pulse) and rsp_tag_out = rsp_tag_in.
  - Response for a non-busy tag: no route, tag_error_out set.
- Simultaneous issue and response in the same cycle:
  - both take effect;
  - a tag freed in cycle N is not allocatable before cycle N+1;
  - outstanding_out is unchanged.
- Full: outstanding = 2^TAG_W → no grants; the cycle after a response frees a tag, grants resume.
- outstanding_out = popcount(busy), registered; counts tags from grant, including a command still waiting in the slot.

Test Plan:
- Reset, enabled_in = 1, only requester 2 valid, payload 0xA5 → cycle after accept: cmd_valid_out = 1, payload 0xA5, tag 0, outstanding 1, RR pointer 3.
- All 4 requesters valid continuously, cmd_ready_in = 1 → grant order 0,1,2,3,0; tags 0..4 assigned in order.
- Issue 16 commands with no responses → outstanding = 16, req_ready_out = 0; one response tag 5 → tag 5 reissued on the next grant, outstanding back to 16.
- cmd_ready_in = 0 for 3 cycles with cmd_valid_out = 1 → payload and tag stable, no new grant; released on cmd_ready_in = 1.
- Response tag 3 owned by requester 1 in the same cycle as a new grant → rsp_valid_out = 0b0010 and rsp_tag_out = 3 next cycle; new grant does not get tag 3.
- Drain: 2 reads outstanding, drop enabled_in → state DRAIN, no grants, idle_out = 0; after both responses → idle_out = 1. Response tag 7 not busy → tag_error_out = 1 and stays 1.
